// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory port.
// The arbiter connects through "slave"; the requester/memory side uses "master".
interface rv32i_mem_arbiter_if #(
    parameter int MEM_AW = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [1:0]        d_size;
    logic              d_uns;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_uns, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, d_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_uns, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, d_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Two-cycle round-robin arbiter sharing one word-wide memory port between
// instruction fetch and load/store, with store lane steering and load extension.
module rv32i_mem_arbiter #(
    parameter int MEM_AW = 10
) (
    input  logic                clk_RV,
    input  logic                rst_RV,
    rv32i_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT, D_ERR} state_t;

    state_t     state_reg;
    logic       last_grant_reg;   // 1 = data was granted last
    logic [1:0] addr_lo_reg;
    logic [1:0] size_reg;
    logic       uns_reg;
    logic       we_reg;

    logic        d_valid;
    logic        idle;
    logic        grant_if;
    logic        grant_d;
    logic        issue_d;
    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic        in_if;
    logic        in_d;
    logic        in_err;

    always_comb begin
        case (bus.d_size)
            2'b00:   d_valid = 1'b1;
            2'b01:   d_valid = ~bus.d_addr[0];
            2'b10:   d_valid = (bus.d_addr[1:0] == 2'b00);
            default: d_valid = 1'b0;
        endcase
    end

    // Reset masks issue in the same cycle so nothing reaches memory while held.
    assign idle     = (state_reg == IDLE) && !rst_RV;
    assign grant_if = idle && bus.if_req && (!bus.d_req || last_grant_reg);
    assign grant_d  = idle && bus.d_req && (!bus.if_req || !last_grant_reg);
    assign issue_d  = grant_d && d_valid;

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;
        if (grant_if) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr[MEM_AW+1:2];
        end else if (issue_d) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.d_addr[MEM_AW+1:2];
            if (bus.d_we) begin
                case (bus.d_size)
                    2'b00: begin
                        bus.mem_we    = 4'b0001 << bus.d_addr[1:0];
                        bus.mem_wdata = {4{bus.d_wdata[7:0]}};
                    end
                    2'b01: begin
                        bus.mem_we    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                        bus.mem_wdata = {2{bus.d_wdata[15:0]}};
                    end
                    default: begin
                        bus.mem_we    = 4'b1111;
                        bus.mem_wdata = bus.d_wdata;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_RV) begin
        if (rst_RV) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            addr_lo_reg    <= 2'b00;
            size_reg       <= 2'b00;
            uns_reg        <= 1'b0;
            we_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_if) begin
                        state_reg      <= IF_WAIT;
                        last_grant_reg <= 1'b0;
                    end else if (grant_d) begin
                        state_reg      <= d_valid ? D_WAIT : D_ERR;
                        last_grant_reg <= 1'b1;
                        addr_lo_reg    <= bus.d_addr[1:0];
                        size_reg       <= bus.d_size;
                        uns_reg        <= bus.d_uns;
                        we_reg         <= bus.d_we;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = bus.mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_byte = byte_lane[addr_lo_reg];
        sel_half = addr_lo_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_reg)
            2'b00:   load_data = {{24{~uns_reg & sel_byte[7]}}, sel_byte};
            2'b01:   load_data = {{16{~uns_reg & sel_half[15]}}, sel_half};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // Responses decode from state; a reset arriving mid-response suppresses them.
    assign in_if  = (state_reg == IF_WAIT) && !rst_RV;
    assign in_d   = (state_reg == D_WAIT)  && !rst_RV;
    assign in_err = (state_reg == D_ERR)   && !rst_RV;

    assign bus.if_ack   = in_if;
    assign bus.if_rdata = in_if ? bus.mem_rdata : 32'h0;
    assign bus.d_ack    = in_d | in_err;
    assign bus.d_err    = in_err;
    assign bus.d_rdata  = (in_d && !we_reg) ? load_data : 32'h0;

    logic unused_bits;
    assign unused_bits = ^{bus.if_addr[31:MEM_AW+2], bus.if_addr[1:0], bus.d_addr[31:MEM_AW+2]};
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: reset, arbitration order, store lanes,
// load extension, error responses and reset during a pending response.
module tb_rv32i_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    rv32i_mem_arbiter_if #(.MEM_AW(10)) bus ();

    rv32i_mem_arbiter #(.MEM_AW(10)) dut (
        .clk_RV (clk),
        .rst_RV (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
        $display("check %-18s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        bus.d_req   = req;
        bus.d_we    = we;
        bus.d_size  = size;
        bus.d_uns   = uns;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0000_0020;
        bus.mem_rdata = 32'h0;
        set_d(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);

        // Reset held with both requests high: nothing may issue or respond.
        step();
        @(negedge clk);
        chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_acks", 32'({bus.if_ack, bus.d_ack, bus.d_err}), 32'h0);
        step();
        rst = 1'b0;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", 32'({bus.mem_en, bus.mem_we, bus.if_ack, bus.d_ack, bus.d_err}), 32'h0);
        chk("post_rst_rdata", bus.d_rdata | bus.if_rdata, 32'h0);
        step();

        // Tie held: fetch, data, fetch, data; acks never together.
        bus.if_req    = 1'b1;
        bus.d_req     = 1'b1;
        bus.mem_rdata = 32'hCAFE_0001;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            case (c % 4)
                0: begin
                    chk("tie_if_issue", 32'({bus.mem_en, bus.mem_addr}), 32'h408);
                    chk("tie_acks0", 32'({bus.if_ack, bus.d_ack}), 32'h0);
                end
                1: begin
                    chk("tie_if_ack", 32'({bus.if_ack, bus.d_ack, bus.mem_en}), 32'h4);
                    chk("tie_if_rdata", bus.if_rdata, 32'hCAFE_0001);
                end
                2: begin
                    chk("tie_d_issue", 32'({bus.mem_en, bus.mem_addr}), 32'h404);
                    chk("tie_acks2", 32'({bus.if_ack, bus.d_ack}), 32'h0);
                end
                default: begin
                    chk("tie_d_ack", 32'({bus.if_ack, bus.d_ack, bus.mem_en}), 32'h2);
                    chk("tie_d_rdata", bus.d_rdata, 32'hCAFE_0001);
                end
            endcase
            step();
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;

        // Single fetch.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0008;
        @(negedge clk);
        chk("if_issue", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'h4002);
        step();
        bus.if_req    = 1'b0;
        bus.mem_rdata = 32'h0000_0093;
        @(negedge clk);
        chk("if_ack", 32'({bus.if_ack, bus.d_ack}), 32'h2);
        chk("if_rdata", bus.if_rdata, 32'h0000_0093);
        step();

        // Byte store at offset 3.
        set_d(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00AB);
        @(negedge clk);
        chk("sb_we_addr", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'h6004);
        chk("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        step();
        bus.d_req     = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("sb_ack", 32'({bus.d_ack, bus.d_err, bus.if_ack}), 32'h4);
        chk("sb_rdata", bus.d_rdata, 32'h0);
        step();

        // Signed half load; attributes changed during the wait must not matter.
        set_d(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0);
        @(negedge clk);
        chk("lh_issue", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'h4000);
        step();
        set_d(1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_0000, 32'h0);
        bus.mem_rdata = 32'h8001_1234;
        @(negedge clk);
        chk("lh_signed", bus.d_rdata, 32'hFFFF_8001);
        step();

        set_d(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0);
        step();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("lhu", bus.d_rdata, 32'h0000_8001);
        step();

        // Signed byte load from lane 1 at an address past the memory size (wraps).
        set_d(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1405, 32'h0);
        @(negedge clk);
        chk("lb_wrap_addr", 32'({bus.mem_en, bus.mem_addr}), 32'h501);
        step();
        bus.d_req     = 1'b0;
        bus.mem_rdata = 32'h0000_F000;
        @(negedge clk);
        chk("lb_signed", bus.d_rdata, 32'hFFFF_FFF0);
        step();

        // Upper half store.
        set_d(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_BEEF);
        @(negedge clk);
        chk("sh_we", 32'(bus.mem_we), 32'hC);
        chk("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
        step();
        bus.d_req = 1'b0;
        step();

        // Misaligned word load and reserved size both give an error response.
        set_d(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
        bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("lw_mis_no_en", 32'({bus.mem_en, bus.mem_we}), 32'h0);
        step();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("lw_mis_err", 32'({bus.d_ack, bus.d_err, bus.if_ack}), 32'h6);
        chk("lw_mis_rdata", bus.d_rdata, 32'h0);
        step();

        set_d(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        @(negedge clk);
        chk("rsv_no_en", 32'(bus.mem_en), 32'h0);
        step();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("rsv_err", 32'({bus.d_ack, bus.d_err}), 32'h3);
        step();

        // Reset during D_WAIT drops the response; a tie afterwards goes to fetch.
        set_d(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
        step();
        bus.d_req = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("rst_dwait_ack", 32'({bus.d_ack, bus.d_err}), 32'h0);
        chk("rst_dwait_rdata", bus.d_rdata, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_ack", 32'({bus.d_ack, bus.if_ack, bus.mem_en}), 32'h0);
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0020;
        set_d(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        @(negedge clk);
        chk("rst_tie_if", 32'({bus.mem_en, bus.mem_addr}), 32'h408);
        step();
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
        chk("rst_tie_ack", 32'({bus.if_ack, bus.d_ack}), 32'h2);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
